dma_address_gen: RTL
====================

// Module: dma_address_gen
// PURPOSE
//  Per-channel address/word-count engine of the DMA controller; directly upstream of the IO buffer.
//  CPU programs base address/count through the low register index (0..7, 0xC) decoded by the IO buffer.
//  During service, presents the channel's current address on address_in and holds it until the buffer acks.
//  Then steps address/count, flags terminal count (TC) and optionally auto-reloads from the base registers.
// PARAMETERS
//  NCH    4   number of channels (chan_sel width = 2)
//  AW     16  address / count width
// PORTS
//  clk         in   1   single clock, all state on posedge
//  Reset       in   1   asynchronous, active-low reset
//  prog_wr     in   1   CPU register write strobe (1 cycle)
//  prog_addr   in   4   register index from IO buffer out_address
//  prog_data   in   8   CPU data byte
//  req         in   1   start service pulse (1 cycle, sampled only in IDLE)
//  chan_sel    in   2   channel to serve, latched with req
//  dec_mode    in   1   1 = address decrements, latched with req
//  block_mode  in   1   1 = run until TC, 0 = single word, latched with req
//  autoinit    in   1   1 = reload current from base at TC, latched with req
//  abort       in   1   return to IDLE immediately, no register update
//  addr_ack    in   1   IO buffer consumed address (IReady handshake)
//  address_in  out  16  current address to IO buffer
//  addr_valid  out  1   address_in valid, held until addr_ack
//  tc          out  1   terminal-count pulse (1 cycle)
//  done        out  1   service finished pulse (1 cycle)
//  busy        out  1   1 whenever state != IDLE
// BEHAVIOUR
//  Reset (Reset=0, async): all base/current regs = 0, byte pointer = low, state IDLE,
//   address_in=0, addr_valid=0, tc=0, done=0, busy=0.
//  Programming (only when busy=0; writes while busy are ignored, no pointer toggle):
//   idx 2n = address ch n, idx 2n+1 = count ch n (n=0..3). Byte pointer selects low then high byte,
//   toggles on every accepted write to 0..7. Write updates base AND current register byte.
//   idx 0xC = clear byte pointer to low. Other indices ignored.
//  States: IDLE -> PRESENT -> WAIT_ACK -> UPDATE -> {PRESENT | IDLE}.
//   IDLE: req=1 latches chan_sel/modes, next PRESENT.
//   PRESENT: address_in <= current addr[ch], addr_valid <= 1; next WAIT_ACK (1 cycle latency req->valid=2 clk).
//   WAIT_ACK: hold address_in/addr_valid stable; addr_ack=1 -> addr_valid <= 0, next UPDATE.
//   UPDATE: addr <= addr +1 (or -1 if dec_mode), modulo 2^16 (0xFFFF+1=0, 0-1=0xFFFF).
//    count==0 before step -> TC: tc=1 one cycle, count becomes 0xFFFF; if autoinit, current
//    addr/count <= base (reload overrides step); done=1, next IDLE regardless of block_mode.
//    else count <= count-1; block_mode -> PRESENT, single -> done=1, next IDLE.
//  Count semantics: programmed N transfers N+1 words (8237 style).
//  abort in any non-IDLE state: next IDLE, addr_valid=0, no update, no tc, done=0.
//  abort and addr_ack same cycle: abort wins. req while busy: ignored.
//  Reset mid-operation: all state to reset values asynchronously, programming lost.
// TESTING
//  1 Reset: drive Reset=0 mid-block transfer -> all outputs 0, state IDLE, current regs 0.
//  2 Program ch1 addr 0x1234 (idx2: 0x34,0x12) count 0x0002 -> req single inc: address_in=0x1234,
//    ack -> done, current addr 0x1235, count 0x0001, tc=0.
//  3 ch0 addr 0x0010 count 2 block inc, ack each word -> addresses 0x10,0x11,0x12; tc pulse on 3rd; done.
//  4 ch2 addr 0x0000 count 0 dec -> address_in 0x0000, tc=1, addr wraps to 0xFFFF, count 0xFFFF;
//    repeat with autoinit=1 -> current reloads to 0x0000/0x0000.
//  5 Byte pointer: write idx4 0xAA, write idx 0xC, write idx4 0xBB -> ch2 addr low byte 0xBB, high unchanged.
//  6 abort with addr_ack same cycle in WAIT_ACK -> IDLE, addr unchanged, no tc/done; prog_wr while busy ignored.

Source files
------------

// File: rtl/dma_address_gen_if.sv
// Address handshake and CPU programming bus between the DMA address engine
// and the IO buffer.
interface dma_address_gen_if #(
  parameter int AW = 16
);
  logic          prog_wr;
  logic [3:0]    prog_addr;
  logic [7:0]    prog_data;
  logic [AW-1:0] address_in;
  logic          addr_valid;
  logic          addr_ack;

  // Address engine side: consumes register writes, presents addresses.
  modport master (
    input  prog_wr,
    input  prog_addr,
    input  prog_data,
    input  addr_ack,
    output address_in,
    output addr_valid
  );

  // IO buffer / CPU side.
  modport slave (
    output prog_wr,
    output prog_addr,
    output prog_data,
    output addr_ack,
    input  address_in,
    input  addr_valid
  );
endinterface

// File: rtl/dma_address_gen.sv
// Per-channel DMA address/word-count engine.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  IDLE     | not serving; CPU may program base/current registers
//  PRESENT  | load current address of the served channel onto the bus
//  WAIT_ACK | hold address and valid until the IO buffer acknowledges
//  UPDATE   | step address/count, flag terminal count, maybe reload
//
// A programmed count of N moves N+1 words; TC fires on the word that
// finds the count already at zero.
module dma_address_gen #(
  parameter int NCH = 4,
  parameter int AW  = 16,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           Reset,
  dma_address_gen_if.master bus,
  input  logic           req,
  input  logic [CW-1:0]  chan_sel,
  input  logic           dec_mode,
  input  logic           block_mode,
  input  logic           autoinit,
  input  logic           abort,
  output logic           tc,
  output logic           done,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESENT  = 2'd1,
    WAIT_ACK = 2'd2,
    UPDATE   = 2'd3
  } state_t;

  state_t state, next_state;

  logic [AW-1:0] base_addr [NCH];
  logic [AW-1:0] base_cnt  [NCH];
  logic [AW-1:0] cur_addr  [NCH];
  logic [AW-1:0] cur_cnt   [NCH];
  logic          byte_hi;

  logic [CW-1:0] ch_q;
  logic          dec_q;
  logic          blk_q;
  logic          ainit_q;

  logic [CW-1:0] prog_ch;
  logic          prog_en;
  logic          prog_clr;
  logic          upd_en;
  logic [AW-1:0] act_addr;
  logic [AW-1:0] act_cnt;
  logic [AW-1:0] step_addr;

  assign busy     = (state != IDLE);
  assign prog_ch  = CW'(bus.prog_addr[2:1]);
  // Register writes are only honoured while idle; index 8..15 except 0xC are no-ops.
  assign prog_en  = bus.prog_wr && (state == IDLE) && !bus.prog_addr[3];
  assign prog_clr = bus.prog_wr && (state == IDLE) && (bus.prog_addr == 4'hC);
  assign upd_en   = (state == UPDATE) && !abort;
  assign act_addr = cur_addr[ch_q];
  assign act_cnt  = cur_cnt[ch_q];
  assign step_addr = dec_q ? (act_addr - AW'(1)) : (act_addr + AW'(1));

  // State register.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode plus the single-cycle tc/done strobes raised in UPDATE.
  always_comb begin
    next_state = state;
    tc         = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:     if (req) next_state = PRESENT;
      PRESENT:  next_state = WAIT_ACK;
      WAIT_ACK: if (bus.addr_ack) next_state = UPDATE;
      UPDATE: begin
        if (act_cnt == '0) begin
          tc         = 1'b1;
          done       = 1'b1;
          next_state = IDLE;
        end else if (blk_q) begin
          next_state = PRESENT;
        end else begin
          done       = 1'b1;
          next_state = IDLE;
        end
      end
      default:  next_state = IDLE;
    endcase
    // Abort beats everything, including a same-cycle ack.
    if (abort && (state != IDLE)) begin
      next_state = IDLE;
      tc         = 1'b0;
      done       = 1'b0;
    end
  end

  // Service parameters captured with the start request.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      ch_q    <= '0;
      dec_q   <= 1'b0;
      blk_q   <= 1'b0;
      ainit_q <= 1'b0;
    end else if ((state == IDLE) && req) begin
      ch_q    <= chan_sel;
      dec_q   <= dec_mode;
      blk_q   <= block_mode;
      ainit_q <= autoinit;
    end
  end

  // Address presentation towards the IO buffer; address stays put after the ack.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      bus.address_in <= '0;
      bus.addr_valid <= 1'b0;
    end else if (abort && (state != IDLE)) begin
      bus.addr_valid <= 1'b0;
    end else if (state == PRESENT) begin
      bus.address_in <= act_addr;
      bus.addr_valid <= 1'b1;
    end else if ((state == WAIT_ACK) && bus.addr_ack) begin
      bus.addr_valid <= 1'b0;
    end
  end

  // Channel register file: CPU byte writes while idle, address/count step in UPDATE.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NCH; i++) begin
        base_addr[i] <= '0;
        base_cnt[i]  <= '0;
        cur_addr[i]  <= '0;
        cur_cnt[i]   <= '0;
      end
      byte_hi <= 1'b0;
    end else begin
      if (prog_en) begin
        if (!bus.prog_addr[0]) begin
          if (!byte_hi) begin
            base_addr[prog_ch][7:0]  <= bus.prog_data;
            cur_addr[prog_ch][7:0]   <= bus.prog_data;
          end else begin
            base_addr[prog_ch][15:8] <= bus.prog_data;
            cur_addr[prog_ch][15:8]  <= bus.prog_data;
          end
        end else begin
          if (!byte_hi) begin
            base_cnt[prog_ch][7:0]   <= bus.prog_data;
            cur_cnt[prog_ch][7:0]    <= bus.prog_data;
          end else begin
            base_cnt[prog_ch][15:8]  <= bus.prog_data;
            cur_cnt[prog_ch][15:8]   <= bus.prog_data;
          end
        end
        byte_hi <= ~byte_hi;
      end else if (prog_clr) begin
        byte_hi <= 1'b0;
      end

      if (upd_en) begin
        if (act_cnt == '0) begin
          // Terminal count: autoinit reload takes precedence over the step.
          if (ainit_q) begin
            cur_addr[ch_q] <= base_addr[ch_q];
            cur_cnt[ch_q]  <= base_cnt[ch_q];
          end else begin
            cur_addr[ch_q] <= step_addr;
            cur_cnt[ch_q]  <= '1;
          end
        end else begin
          cur_addr[ch_q] <= step_addr;
          cur_cnt[ch_q]  <= act_cnt - AW'(1);
        end
      end
    end
  end

endmodule
